// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache miss path.
// Line geometry is fixed at 4 words of 32 bits.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} refill_state_t;

  localparam int OFFSET_BITS      = 2;
  localparam int BYTE_OFFSET_BITS = 2;
  localparam int LINE_BYTES       = 16;

  typedef logic [31:0] word_t;

  function automatic word_t line_base(input word_t addr);
    return addr & ~word_t'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/refill_line_buf.sv
// Purpose: 4x32 capture register assembling a cache line one beat at a time.
// Latency: write visible on d0..d3 the cycle after we; reads are combinational.
// Backpressure: none; accepts a word on every cycle we is high.
module refill_line_buf
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [OFFSET_BITS-1:0] idx,
  input  word_t                  data,
  output word_t                  d0,
  output word_t                  d1,
  output word_t                  d2,
  output word_t                  d3
);

  word_t mem_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[idx] <= data;
    end
  end

  assign d0 = mem_q[0];
  assign d1 = mem_q[1];
  assign d2 = mem_q[2];
  assign d3 = mem_q[3];

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Purpose: read-miss refill of a 4-word line from memory; DCACHE_CRITICAL_WORD_FIRST_EN selects wrapped fetch.
// Latency: stall spans the miss cycle plus 4*(L+1)+1 cycles for per-beat memory latency L.
// Backpressure: pipeline frozen via stall; each request held until mem_rvalid.
module dcache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss,
  input  logic [DATA_WIDTH-1:0] miss_addr,
  output logic                  stall,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  line_we,
  output logic [DATA_WIDTH-1:0] line_addr,
  output logic [DATA_WIDTH-1:0] line_d0,
  output logic [DATA_WIDTH-1:0] line_d1,
  output logic [DATA_WIDTH-1:0] line_d2,
  output logic [DATA_WIDTH-1:0] line_d3,
  output logic                  fwd_valid,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  if (WORDS_PER_LINE != 4 || DATA_WIDTH != 32) begin : g_param_check
    $error("dcache_refill_ctrl supports only DATA_WIDTH=32 and WORDS_PER_LINE=4");
  end

  refill_state_t          state_q, state_d;
  word_t                  base_q;
  logic [OFFSET_BITS-1:0] ptr_q;
  logic [1:0]             cnt_q;
  logic                   beat;
`ifndef DCACHE_CRITICAL_WORD_FIRST_EN
  logic [OFFSET_BITS-1:0] off_q;
`endif

  assign beat = (state_q == FETCH) && mem_rvalid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = FETCH;
      FETCH:   if (mem_rvalid && cnt_q == 2'd3) state_d = WRITE;
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Refill context is captured only from IDLE, so a frozen pipeline cannot move the line base.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
`ifndef DCACHE_CRITICAL_WORD_FIRST_EN
      off_q  <= '0;
`endif
    end else if (state_q == IDLE && miss) begin
      base_q <= line_base(miss_addr);
      cnt_q  <= '0;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      ptr_q  <= miss_addr[BYTE_OFFSET_BITS +: OFFSET_BITS];
`else
      ptr_q  <= '0;
      off_q  <= miss_addr[BYTE_OFFSET_BITS +: OFFSET_BITS];
`endif
    end else if (beat) begin
      ptr_q <= ptr_q + 2'd1;
      cnt_q <= cnt_q + 2'd1;
    end
  end

  refill_line_buf u_line_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (beat),
    .idx  (ptr_q),
    .data (mem_rdata),
    .d0   (line_d0),
    .d1   (line_d1),
    .d2   (line_d2),
    .d3   (line_d3)
  );

  assign line_addr = base_q;

  always_comb begin
    stall     = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    line_we   = 1'b0;
    fwd_valid = 1'b0;
    fwd_data  = '0;
    case (state_q)
      IDLE: stall = miss;
      FETCH: begin
        stall     = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = {base_q[31:4], ptr_q, 2'b00};
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
        if (mem_rvalid && cnt_q == 2'd0) begin
          fwd_valid = 1'b1;
          fwd_data  = mem_rdata;
        end
`endif
      end
      WRITE: begin
        stall   = 1'b1;
        line_we = 1'b1;
`ifndef DCACHE_CRITICAL_WORD_FIRST_EN
        fwd_valid = 1'b1;
        case (off_q)
          2'd0:    fwd_data = line_d0;
          2'd1:    fwd_data = line_d1;
          2'd2:    fwd_data = line_d2;
          default: fwd_data = line_d3;
        endcase
`endif
      end
      default: ;
    endcase
  end

endmodule
